// File: rtl/rd_phase_guard_pkg.sv
// Shared types for the AXI read-channel phase watchdog: slot record,
// phase/cause/FSM encodings and the default AXI request/response structs.
package rd_phase_guard_pkg;

   localparam int IdW  = 4;
   localparam int CntW = 16;

   typedef logic [IdW-1:0]  id_t;
   typedef logic [CntW-1:0] cnt_t;

   typedef enum logic {
      PH_WAIT_FIRST = 1'b0,
      PH_IN_BURST   = 1'b1
   } phase_e;

   typedef enum logic [1:0] {
      CAUSE_NONE       = 2'd0,
      CAUSE_FIRST_BEAT = 2'd1,
      CAUSE_BEAT       = 2'd2,
      CAUSE_PROTOCOL   = 2'd3
   } cause_e;

   typedef enum logic [1:0] {
      ST_MONITOR = 2'd0,
      ST_FAULT   = 2'd1,
      ST_FLUSH   = 2'd2
   } fsm_e;

   typedef struct packed {
      id_t id;
   } ar_chan_t;

   typedef struct packed {
      id_t  id;
      logic last;
   } r_chan_t;

   typedef struct packed {
      logic     ar_valid;
      ar_chan_t ar;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    ar_ready;
      logic    r_valid;
      r_chan_t r;
   } axi_rsp_t;

   // One tracked ID: its outstanding burst count and the running phase timer
   typedef struct packed {
      logic   valid;
      id_t    id;
      cnt_t   count;
      phase_e phase;
      cnt_t   timer;
   } slot_t;

endpackage

// File: rtl/rd_phase_guard_slot.sv
// One ID-table entry: ID compare, burst count and phase tracking, phase timer
// and expiry flag. All updates are qualified by upd_i from the top level.
module rd_phase_slot
   import rd_phase_guard_pkg::*;
#(
   parameter int MaxTxnsPerId = 4
) (
   input  logic   clk_i,
   input  logic   rst_ni,
   input  logic   flush_i,
   input  logic   upd_i,
   input  logic   tick_i,
   input  logic   ar_hs_i,
   input  id_t    ar_id_i,
   input  logic   alloc_i,
   input  logic   r_hs_i,
   input  id_t    r_id_i,
   input  logic   r_last_i,
   input  cnt_t   addr_budget_i,
   input  cnt_t   beat_budget_i,
   output logic   valid_o,
   output id_t    id_o,
   output cnt_t   count_o,
   output phase_e phase_o,
   output logic   ar_match_o,
   output logic   r_match_o,
   output logic   count_full_o,
   output logic   expired_o
);

   slot_t slot_q, slot_d;
   logic  ar_hit;
   logic  r_hit;

   assign ar_match_o   = slot_q.valid && (slot_q.id == ar_id_i);
   assign r_match_o    = slot_q.valid && (slot_q.id == r_id_i);
   assign count_full_o = slot_q.valid && (slot_q.count == cnt_t'(MaxTxnsPerId));
   assign ar_hit       = upd_i && ar_hs_i && ar_match_o && !count_full_o;
   assign r_hit        = upd_i && r_hs_i && r_match_o;

   // A tick on an exhausted timer expires the slot unless an R beat lands on it now
   assign expired_o = slot_q.valid && tick_i && (slot_q.timer == '0) && !(r_hs_i && r_match_o);

   assign valid_o = slot_q.valid;
   assign id_o    = slot_q.id;
   assign count_o = slot_q.count;
   assign phase_o = slot_q.phase;

   // Slot next state: flush, allocation, R-beat phase changes, AR count, timer
   always_comb begin
      slot_d = slot_q;
      if (flush_i) begin
         slot_d.valid = 1'b0;
      end else if (upd_i && alloc_i) begin
         slot_d.valid = 1'b1;
         slot_d.id    = ar_id_i;
         slot_d.count = cnt_t'(1);
         slot_d.phase = PH_WAIT_FIRST;
         slot_d.timer = addr_budget_i;
      end else if (slot_q.valid) begin
         if (r_hit) begin
            if (r_last_i) begin
               if (ar_hit) begin
                  // New burst replaces the finished one: count nets to zero change
                  slot_d.phase = PH_WAIT_FIRST;
                  slot_d.timer = addr_budget_i;
               end else if (slot_q.count > cnt_t'(1)) begin
                  slot_d.count = slot_q.count - cnt_t'(1);
                  slot_d.phase = PH_WAIT_FIRST;
                  slot_d.timer = addr_budget_i;
               end else begin
                  slot_d.valid = 1'b0;
               end
            end else begin
               slot_d.phase = PH_IN_BURST;
               slot_d.timer = beat_budget_i;
               if (ar_hit) begin
                  slot_d.count = slot_q.count + cnt_t'(1);
               end
            end
         end else begin
            if (ar_hit) begin
               slot_d.count = slot_q.count + cnt_t'(1);
            end
            if (upd_i && tick_i && (slot_q.timer != '0)) begin
               slot_d.timer = slot_q.timer - cnt_t'(1);
            end
         end
      end
   end

   // Slot state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

endmodule

// File: rtl/rd_phase_guard.sv
// AXI read-channel watchdog. Tracks outstanding read bursts per ID, times the
// AR-to-first-beat and beat-to-beat phases of each ID's head burst, and latches
// a fault (timeout, orphan R beat or table overflow) until acknowledged.
module rd_phase_guard
   import rd_phase_guard_pkg::*;
#(
   parameter int  MaxUniqIds   = 8,
   parameter int  MaxTxnsPerId = 4,
   parameter int  CntWidth     = 16,
   parameter int  PrescalerDiv = 1,
   parameter type req_t        = axi_req_t,
   parameter type rsp_t        = axi_rsp_t,
   localparam int OutW         = $clog2(MaxUniqIds * MaxTxnsPerId + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  req_t                mst_req_i,
   input  rsp_t                slv_rsp_i,
   input  logic [CntWidth-1:0] addr_budget_i,
   input  logic [CntWidth-1:0] beat_budget_i,
   input  logic                clear_i,
   output logic                full_o,
   output logic                reset_req_o,
   output logic                irq_o,
   output logic [1:0]          fault_cause_o,
   output id_t                 fault_id_o,
   output logic [OutW-1:0]     outstanding_o
);

   localparam int PreW = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

   fsm_e            state_q, state_d;
   logic            reset_req_q, reset_req_d;
   logic            irq_q, irq_d;
   cause_e          cause_q, cause_d;
   id_t             fault_id_q, fault_id_d;
   logic [PreW-1:0] pre_q, pre_d;

   logic tick;
   logic monitor;
   logic ar_hs, r_hs;
   logic upd;

   logic [MaxUniqIds-1:0] slot_valid, ar_match, r_match, count_full, expired;
   logic [MaxUniqIds-1:0] free_oh, alloc_vec;
   id_t                   slot_id    [MaxUniqIds];
   cnt_t                  slot_count [MaxUniqIds];
   phase_e                slot_phase [MaxUniqIds];

   logic   any_free, ar_match_any, ar_match_full, r_match_any;
   logic   exp_any;
   cause_e exp_cause;
   id_t    exp_id;
   logic   ar_ovf, r_orphan;
   logic   fault_det;
   cause_e fault_cause;
   id_t    fault_id;

   logic [OutW-1:0] out_sum;

   assign monitor = (state_q == ST_MONITOR);
   assign ar_hs   = monitor && en_i && mst_req_i.ar_valid && slv_rsp_i.ar_ready;
   assign r_hs    = monitor && slv_rsp_i.r_valid && mst_req_i.r_ready;

   // Timer tick prescaler, free running
   assign tick  = (pre_q == PreW'(PrescalerDiv - 1));
   assign pre_d = tick ? '0 : pre_q + PreW'(1);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   for (genvar g = 0; g < MaxUniqIds; g++) begin : g_slot
      rd_phase_slot #(
         .MaxTxnsPerId(MaxTxnsPerId)
      ) u_slot (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .flush_i      (state_q == ST_FLUSH),
         .upd_i        (upd),
         .tick_i       (tick && monitor),
         .ar_hs_i      (ar_hs),
         .ar_id_i      (mst_req_i.ar.id),
         .alloc_i      (alloc_vec[g]),
         .r_hs_i       (r_hs),
         .r_id_i       (slv_rsp_i.r.id),
         .r_last_i     (slv_rsp_i.r.last),
         .addr_budget_i(cnt_t'(addr_budget_i)),
         .beat_budget_i(cnt_t'(beat_budget_i)),
         .valid_o      (slot_valid[g]),
         .id_o         (slot_id[g]),
         .count_o      (slot_count[g]),
         .phase_o      (slot_phase[g]),
         .ar_match_o   (ar_match[g]),
         .r_match_o    (r_match[g]),
         .count_full_o (count_full[g]),
         .expired_o    (expired[g])
      );
   end

   // Lowest-index free slot, one-hot
   always_comb begin
      free_oh  = '0;
      any_free = 1'b0;
      for (int i = 0; i < MaxUniqIds; i++) begin
         if (!slot_valid[i] && !any_free) begin
            free_oh[i] = 1'b1;
            any_free   = 1'b1;
         end
      end
   end

   assign ar_match_any  = |ar_match;
   assign ar_match_full = |(ar_match & count_full);
   assign r_match_any   = |r_match;
   assign full_o        = !any_free || ar_match_full;

   // Lowest-index expiring slot and its cause
   always_comb begin
      exp_any   = 1'b0;
      exp_cause = CAUSE_NONE;
      exp_id    = '0;
      for (int i = 0; i < MaxUniqIds; i++) begin
         if (expired[i] && !exp_any) begin
            exp_any   = 1'b1;
            exp_cause = (slot_phase[i] == PH_IN_BURST) ? CAUSE_BEAT : CAUSE_FIRST_BEAT;
            exp_id    = slot_id[i];
         end
      end
   end

   assign ar_ovf   = ar_hs && (ar_match_any ? ar_match_full : !any_free);
   assign r_orphan = r_hs && !r_match_any;

   // Fault detection: timeouts take precedence over overflow, then orphan R
   always_comb begin
      fault_det   = 1'b1;
      fault_cause = CAUSE_NONE;
      fault_id    = '0;
      if (exp_any) begin
         fault_cause = exp_cause;
         fault_id    = exp_id;
      end else if (ar_ovf) begin
         fault_cause = CAUSE_PROTOCOL;
         fault_id    = mst_req_i.ar.id;
      end else if (r_orphan) begin
         fault_cause = CAUSE_PROTOCOL;
         fault_id    = slv_rsp_i.r.id;
      end else begin
         fault_det = 1'b0;
      end
   end

   // Table updates are frozen outside MONITOR and on the cycle a fault is seen
   assign upd       = monitor && !fault_det;
   assign alloc_vec = (upd && ar_hs && !ar_match_any) ? free_oh : '0;

   // Total outstanding bursts over valid slots
   always_comb begin
      out_sum = '0;
      for (int i = 0; i < MaxUniqIds; i++) begin
         if (slot_valid[i]) begin
            out_sum = out_sum + OutW'(slot_count[i]);
         end
      end
   end

   assign outstanding_o = out_sum;

   // FSM state and fault report registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_MONITOR;
         reset_req_q <= 1'b0;
         irq_q       <= 1'b0;
         cause_q     <= CAUSE_NONE;
         fault_id_q  <= '0;
      end else begin
         state_q     <= state_d;
         reset_req_q <= reset_req_d;
         irq_q       <= irq_d;
         cause_q     <= cause_d;
         fault_id_q  <= fault_id_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_MONITOR: if (fault_det) state_d = ST_FAULT;
         ST_FAULT:   if (clear_i)   state_d = ST_FLUSH;
         ST_FLUSH:   state_d = ST_MONITOR;
         default:    state_d = ST_MONITOR;
      endcase
   end

   // FSM outputs: latch the report at fault entry, drop it on acknowledge
   always_comb begin
      reset_req_d = reset_req_q;
      irq_d       = 1'b0;
      cause_d     = cause_q;
      fault_id_d  = fault_id_q;
      case (state_q)
         ST_MONITOR: begin
            if (fault_det) begin
               reset_req_d = 1'b1;
               irq_d       = 1'b1;
               cause_d     = fault_cause;
               fault_id_d  = fault_id;
            end
         end
         ST_FAULT: begin
            if (clear_i) begin
               reset_req_d = 1'b0;
               cause_d     = CAUSE_NONE;
               fault_id_d  = '0;
            end
         end
         default: begin
            reset_req_d = 1'b0;
            cause_d     = CAUSE_NONE;
            fault_id_d  = '0;
         end
      endcase
   end

   assign reset_req_o   = reset_req_q;
   assign irq_o         = irq_q;
   assign fault_cause_o = cause_q;
   assign fault_id_o    = fault_id_q;

endmodule
